multiplicador_sequencial: RTL and testbench
===========================================

Name: multiplicador_sequencial

Overview:
- Shift-add sequential multiplier for two unsigned N-bit operands, producing a 2N-bit product.
- Sits directly upstream of the 1-to-5 demultiplexer stage:
  - drives its 3-bit select (`op`) and 16-bit data (`entrada` ← `produto`);
  - routes each finished product to one of five destination words (a..e), chosen at start time.
- Holds `op` at an unused code while no write is in progress, so no destination is selected.

Parameters:
- N, 8, operand width. Product width is 2N, which must equal 16 to match the downstream stage. Only N=8 is supported.
- OP_NENHUM, 3'b111, `op` value driven when no write is in progress (decodes to no destination downstream).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- iniciar  input  1  start request, sampled only in OCIOSO.
- multiplicando  input  N  operand A, latched on accepted start.
- multiplicador  input  N  operand B, latched on accepted start.
- destino  input  3  destination index 0..4, latched on accepted start.
- ocupado  output  1  high while in CALCULA or ESCREVE.
- pronto  output  1  high from completion until the next accepted start.
- erro_destino  output  1  one-cycle pulse when a start is rejected.
- escreve  output  1  one-cycle strobe; `produto` and `op` are valid while it is high.
- op  output  3  destination select to the downstream stage.
- produto  output  2N  product; connects to downstream `entrada`.

Behaviour:
- All outputs are registered.
- Reset values:
  - state = OCIOSO
  - ocupado = 0, pronto = 0, erro_destino = 0, escreve = 0
  - op = OP_NENHUM
  - produto = 0, internal accumulator = 0, step counter = 0
- Reset is asynchronous: it takes effect immediately, including mid-operation. An aborted operation never asserts `escreve`.
- States: OCIOSO, CALCULA, ESCREVE.
- OCIOSO:
  - If iniciar=1 and destino<=4: latch A, B and destino; clear accumulator and counter; pronto←0; ocupado←1; go to CALCULA.
  - If iniciar=1 and destino>=5: erro_destino←1 for one cycle; nothing is latched; pronto keeps its value; stay in OCIOSO.
  - If iniciar=0: stay in OCIOSO and hold all outputs.
- CALCULA (exactly N cycles, step k = 0..N-1):
  - If B[k]=1: accumulator ← accumulator + (A << k), computed at 2N bits. The sum cannot overflow 2N bits.
  - On step k=N-1:
    - produto ← final sum
    - op ← latched destino
    - escreve ← 1
    - go to ESCREVE
  - iniciar is ignored in this state.
  - There is no early termination: B=0 still takes N cycles.
- ESCREVE (one cycle):
  - escreve=1, op=destino, produto is valid.
  - Next edge: escreve←0, op←OP_NENHUM, ocupado←0, pronto←1, go to OCIOSO.
  - iniciar is ignored in this cycle. A start must arrive in OCIOSO; there is no back-to-back start on the same edge.
- Latency: let E0 be the edge that accepts iniciar.
  - escreve is high between edges E_N and E_{N+1}. For N=8, that is cycle 9 after E0.
  - pronto rises at E_{N+1}.
- produto holds the last result until the next ESCREVE or reset. It is not cleared by a new start.
- op equals OP_NENHUM in every cycle where escreve=0.
- Unsigned arithmetic only.

Test Plan:
- Reset, then A=8'hFF, B=8'hFF, destino=0, iniciar for 1 cycle → after exactly 9 cycles: escreve=1 for 1 cycle, produto=16'hFE01, op=3'b000. Then pronto=1, ocupado=0, op=3'b111.
- A=13, B=11, destino=4 → produto=16'h008F, op=3'b100 during the escreve cycle. Also check A=0, B=8'hAB, destino=2 → produto=16'h0000, op=3'b010, still 9 cycles.
- destino=5 with iniciar in OCIOSO → erro_destino=1 for 1 cycle; ocupado, escreve and produto unchanged; op=3'b111. Repeat with destino=7, same result.
- Start A=3, B=5, destino=1; pulse iniciar with A=200, B=200, destino=3 during CALCULA and again during ESCREVE → only one escreve, with produto=15 and op=3'b001.
- Start A=8'hAA, B=8'h55; assert reset at cycle 4 of CALCULA → outputs return to reset values immediately and no escreve occurs. After releasing reset, start A=2, B=7, destino=3 → produto=14, op=3'b011.
- Across all scenarios, assert that op≠OP_NENHUM only while escreve=1, and that escreve is never high for 2 consecutive cycles.

Source files
------------

// File: rtl/multiplicador_sequencial_if.sv
// Start/result bundle between the multiplier and its driver.
// The slave side is the multiplier itself.
interface multiplicador_sequencial_if #(
   parameter int N = 8
);
   logic           iniciar;
   logic [N-1:0]   multiplicando;
   logic [N-1:0]   multiplicador;
   logic [2:0]     destino;
   logic           ocupado;
   logic           pronto;
   logic           erro_destino;
   logic           escreve;
   logic [2:0]     op;
   logic [2*N-1:0] produto;

   modport master (
      output iniciar, multiplicando, multiplicador, destino,
      input  ocupado, pronto, erro_destino, escreve, op, produto
   );

   modport slave (
      input  iniciar, multiplicando, multiplicador, destino,
      output ocupado, pronto, erro_destino, escreve, op, produto
   );
endinterface

// File: rtl/multiplicador_sequencial.sv
// Shift-add unsigned multiplier, N cycles per product, then a
// one-cycle write strobe towards the 1-to-5 demux (op/produto).
module multiplicador_sequencial #(
   parameter int       N          = 8,
   parameter bit [2:0] OP_NENHUM  = 3'b111
) (
   input logic                         clock,
   input logic                         reset,
   multiplicador_sequencial_if.slave   bus
);

   localparam int W = $clog2(N);

   typedef enum logic [1:0] {
      OCIOSO,
      CALCULA,
      ESCREVE
   } state_t;

   state_t         state;
   logic [N-1:0]   a_reg;
   logic [N-1:0]   b_reg;
   logic [2:0]     dest_reg;
   logic [2*N-1:0] acc;
   logic [W-1:0]   cnt;
   logic [2*N-1:0] parcial;
   logic [2*N-1:0] soma;

   // Partial product for the current step and the running sum.
   always_comb begin
      parcial = '0;
      if (b_reg[cnt])
         parcial = {{N{1'b0}}, a_reg} << cnt;
      soma = acc + parcial;
   end

   // Control FSM with all outputs registered.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state            <= OCIOSO;
         a_reg            <= '0;
         b_reg            <= '0;
         dest_reg         <= '0;
         acc              <= '0;
         cnt              <= '0;
         bus.ocupado      <= 1'b0;
         bus.pronto       <= 1'b0;
         bus.erro_destino <= 1'b0;
         bus.escreve      <= 1'b0;
         bus.op           <= OP_NENHUM;
         bus.produto      <= '0;
      end else begin
         bus.erro_destino <= 1'b0;
         unique case (state)
            OCIOSO: begin
               if (bus.iniciar) begin
                  if (bus.destino <= 3'd4) begin
                     a_reg       <= bus.multiplicando;
                     b_reg       <= bus.multiplicador;
                     dest_reg    <= bus.destino;
                     acc         <= '0;
                     cnt         <= '0;
                     bus.pronto  <= 1'b0;
                     bus.ocupado <= 1'b1;
                     state       <= CALCULA;
                  end else begin
                     bus.erro_destino <= 1'b1;
                  end
               end
            end
            CALCULA: begin
               acc <= soma;
               cnt <= cnt + W'(1);
               if (cnt == W'(N - 1)) begin
                  bus.produto <= soma;
                  bus.op      <= dest_reg;
                  bus.escreve <= 1'b1;
                  state       <= ESCREVE;
               end
            end
            ESCREVE: begin
               bus.escreve <= 1'b0;
               bus.op      <= OP_NENHUM;
               bus.ocupado <= 1'b0;
               bus.pronto  <= 1'b1;
               state       <= OCIOSO;
            end
            default: state <= OCIOSO;
         endcase
      end
   end

endmodule

// File: tb/tb_multiplicador_sequencial.sv
// Directed bench for multiplicador_sequencial.
// Hand-computed products, latency, rejection and reset abort.
module tb_multiplicador_sequencial;

   logic clock;
   logic reset;
   int   tests;
   int   failed;
   logic run_mon;
   logic prev_esc;

   multiplicador_sequencial_if #(.N(8)) bus ();

   multiplicador_sequencial #(.N(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic go, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] d);
      bus.iniciar       = go;
      bus.multiplicando = a;
      bus.multiplicador = b;
      bus.destino       = d;
   endtask

   // Full operation: accept edge, 7 quiet edges, strobe, idle.
   task automatic run_mul(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic [2:0] d,
                          input logic [15:0] exp_p);
      drive(1'b1, a, b, d);
      tick();
      drive(1'b0, 8'd0, 8'd0, 3'd0);
      chk({tag, "_busy"}, 32'(bus.ocupado), 32'd1);
      chk({tag, "_pronto0"}, 32'(bus.pronto), 32'd0);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk({tag, "_early"}, 32'(bus.escreve), 32'd0);
      end
      tick();
      chk({tag, "_esc"}, 32'(bus.escreve), 32'd1);
      chk({tag, "_prod"}, 32'(bus.produto), 32'(exp_p));
      chk({tag, "_op"}, 32'(bus.op), 32'(d));
      tick();
      chk({tag, "_esc0"}, 32'(bus.escreve), 32'd0);
      chk({tag, "_pronto"}, 32'(bus.pronto), 32'd1);
      chk({tag, "_ocup0"}, 32'(bus.ocupado), 32'd0);
      chk({tag, "_opnone"}, 32'(bus.op), 32'h7);
      chk({tag, "_hold"}, 32'(bus.produto), 32'(exp_p));
   endtask

   task automatic reject(input logic [2:0] d, input logic [15:0] p);
      drive(1'b1, 8'd9, 8'd9, d);
      tick();
      drive(1'b0, 8'd0, 8'd0, 3'd0);
      chk("rej_err", 32'(bus.erro_destino), 32'd1);
      chk("rej_ocup", 32'(bus.ocupado), 32'd0);
      chk("rej_esc", 32'(bus.escreve), 32'd0);
      chk("rej_prod", 32'(bus.produto), 32'(p));
      chk("rej_op", 32'(bus.op), 32'h7);
      chk("rej_pronto", 32'(bus.pronto), 32'd1);
      tick();
      chk("rej_pulse", 32'(bus.erro_destino), 32'd0);
      chk("rej_idle", 32'(bus.ocupado), 32'd0);
   endtask

   // Global rules: op only selects during escreve; no double strobe.
   always @(negedge clock) begin
      if (run_mon) begin
         chk("mon_op", 32'(bus.escreve || (bus.op == 3'b111)), 32'd1);
         chk("mon_dbl", 32'(prev_esc && bus.escreve), 32'd0);
         prev_esc = bus.escreve;
      end else begin
         prev_esc = 1'b0;
      end
   end

   initial begin
      tests   = 0;
      failed  = 0;
      run_mon = 1'b0;
      reset   = 1'b1;
      drive(1'b0, 8'd0, 8'd0, 3'd0);
      tick();
      tick();
      chk("rst_ocup", 32'(bus.ocupado), 32'd0);
      chk("rst_pronto", 32'(bus.pronto), 32'd0);
      chk("rst_err", 32'(bus.erro_destino), 32'd0);
      chk("rst_esc", 32'(bus.escreve), 32'd0);
      chk("rst_op", 32'(bus.op), 32'h7);
      chk("rst_prod", 32'(bus.produto), 32'd0);
      reset   = 1'b0;
      run_mon = 1'b1;
      tick();

      run_mul("ffxff", 8'hFF, 8'hFF, 3'd0, 16'hFE01);
      run_mul("13x11", 8'd13, 8'd11, 3'd4, 16'h008F);
      run_mul("0xab", 8'd0, 8'hAB, 3'd2, 16'h0000);

      reject(3'd5, 16'h0000);
      reject(3'd7, 16'h0000);

      // Start requests during CALCULA and ESCREVE are ignored.
      drive(1'b1, 8'd3, 8'd5, 3'd1);
      tick();
      drive(1'b0, 8'd0, 8'd0, 3'd0);
      for (int i = 1; i < 8; i++) begin
         if (i == 3)
            drive(1'b1, 8'd200, 8'd200, 3'd3);
         tick();
         drive(1'b0, 8'd0, 8'd0, 3'd0);
         chk("ign_early", 32'(bus.escreve), 32'd0);
      end
      tick();
      chk("ign_esc", 32'(bus.escreve), 32'd1);
      chk("ign_prod", 32'(bus.produto), 32'd15);
      chk("ign_op", 32'(bus.op), 32'd1);
      drive(1'b1, 8'd200, 8'd200, 3'd3);
      tick();
      drive(1'b0, 8'd0, 8'd0, 3'd0);
      chk("ign_esc0", 32'(bus.escreve), 32'd0);
      chk("ign_ocup", 32'(bus.ocupado), 32'd0);
      chk("ign_pronto", 32'(bus.pronto), 32'd1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("ign_quiet", 32'(bus.escreve | bus.ocupado), 32'd0);
         chk("ign_keep", 32'(bus.produto), 32'd15);
      end

      // Asynchronous reset in the middle of CALCULA.
      drive(1'b1, 8'hAA, 8'h55, 3'd2);
      tick();
      drive(1'b0, 8'd0, 8'd0, 3'd0);
      for (int i = 0; i < 4; i++) tick();
      chk("ab_busy", 32'(bus.ocupado), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("ab_ocup", 32'(bus.ocupado), 32'd0);
      chk("ab_pronto", 32'(bus.pronto), 32'd0);
      chk("ab_esc", 32'(bus.escreve), 32'd0);
      chk("ab_op", 32'(bus.op), 32'h7);
      chk("ab_prod", 32'(bus.produto), 32'd0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("ab_quiet", 32'(bus.escreve | bus.ocupado), 32'd0);
      end
      run_mul("2x7", 8'd2, 8'd7, 3'd3, 16'd14);

      tick();
      run_mon = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
